// File: rtl/amber128_dmem.sv
// Single-port 128-bit data memory responder with fixed access latency, fault detection and a backdoor preload port.
// Define AMBER128_DMEM_STALL_EN to add LFSR-driven latency jitter of 0..3 extra cycles.
module amber128_dmem #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter logic [63:0] BASE_ADDR   = 64'h0000_0000_0001_0000,
  parameter int unsigned LATENCY     = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           clk_en_i,
  input  logic                           dmem_req_i,
  input  logic                           dmem_we_i,
  input  logic [63:0]                    dmem_addr_i,
  input  logic [127:0]                   dmem_wdata_i,
  output logic [127:0]                   dmem_rdata_o,
  output logic                           dmem_ready_o,
  output logic                           dmem_trap_o,
  input  logic                           init_we_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0] init_idx_i,
  input  logic [127:0]                   init_data_i,
  output logic                           busy_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W = $clog2(LATENCY + 4);
  localparam logic [63:0] LIMIT = BASE_ADDR + 64'(DEPTH_WORDS) * 64'd16;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t             state_q;
  logic               we_q;
  logic               fault_q;
  logic [IDX_W-1:0]   idx_q;
  logic [127:0]       wdata_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [127:0]       rdata_q;
  logic               ready_q;
  logic               trap_q;
  logic               busy_q;
  logic [127:0]       mem [DEPTH_WORDS];

  logic               req_fault;
  logic [IDX_W-1:0]   req_idx;
  logic [CNT_W-1:0]   req_cnt;
  logic [1:0]         extra;

  logic               acc_fire;
  logic               acc_we;
  logic               acc_fault;
  logic [IDX_W-1:0]   acc_idx;
  logic [127:0]       acc_wdata;

`ifdef AMBER128_DMEM_STALL_EN
  logic [7:0] lfsr_q;
  assign extra = lfsr_q[1:0];
`else
  assign extra = 2'b00;
`endif

  assign req_fault = (dmem_addr_i[3:0] != 4'h0) || (dmem_addr_i < BASE_ADDR) || (dmem_addr_i >= LIMIT);
  assign req_idx   = IDX_W'((dmem_addr_i - BASE_ADDR) >> 4);
  assign req_cnt   = CNT_W'(LATENCY - 1) + CNT_W'(extra);

  // The access can come straight from the request inputs (zero wait count) or from the captured copy.
  always_comb begin
    acc_fire  = 1'b0;
    acc_we    = we_q;
    acc_fault = fault_q;
    acc_idx   = idx_q;
    acc_wdata = wdata_q;
    if (!rst_i && clk_en_i) begin
      if (state_q == S_IDLE && dmem_req_i && req_cnt == '0) begin
        acc_fire  = 1'b1;
        acc_we    = dmem_we_i;
        acc_fault = req_fault;
        acc_idx   = req_idx;
        acc_wdata = dmem_wdata_i;
      end else if (state_q == S_WAIT && cnt_q <= CNT_W'(1)) begin
        acc_fire = 1'b1;
      end
    end
  end

  // Request store is assigned last so it wins over a same-word backdoor write.
  always_ff @(posedge clk_i) begin
    if (init_we_i) mem[init_idx_i] <= init_data_i;
    if (acc_fire && acc_we && !acc_fault) mem[acc_idx] <= acc_wdata;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      fault_q <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      trap_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef AMBER128_DMEM_STALL_EN
      lfsr_q  <= 8'hA5;
`endif
    end else if (clk_en_i) begin
      if (acc_fire) begin
        state_q <= S_RESP;
        busy_q  <= 1'b1;
        ready_q <= 1'b1;
        trap_q  <= acc_fault;
        rdata_q <= (acc_fault || acc_we) ? '0 : mem[acc_idx];
      end
      case (state_q)
        S_IDLE: begin
          if (dmem_req_i) begin
            we_q    <= dmem_we_i;
            fault_q <= req_fault;
            idx_q   <= req_idx;
            wdata_q <= dmem_wdata_i;
            cnt_q   <= req_cnt;
            busy_q  <= 1'b1;
`ifdef AMBER128_DMEM_STALL_EN
            lfsr_q  <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
`endif
            if (!acc_fire) state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!acc_fire) cnt_q <= cnt_q - CNT_W'(1);
        end
        S_RESP: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          ready_q <= 1'b0;
          trap_q  <= 1'b0;
          rdata_q <= '0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign dmem_rdata_o = rdata_q;
  assign dmem_ready_o = ready_q;
  assign dmem_trap_o  = trap_q;
  assign busy_o       = busy_q;

endmodule
